// File: rtl/sd_clk_pkg.sv
// Shared types and defaults for the SD card clock generator.
package sd_clk_pkg;

    // Divider/FSM states.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        IDLE      = 2'd1,
        RUN       = 2'd2
    } state_t;

    // Defaults assume a ~99 MHz PLL clock.
    localparam int DIV_SLOW_DEF  = 125;   // 99 MHz / 250 = 396 kHz
    localparam int DIV_FAST_DEF  = 2;     // 99 MHz / 4 = 24.75 MHz
    localparam int LOCK_WAIT_DEF = 1024;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lock_filter.sv
// PLL lock filter: 2-flop synchroniser followed by a saturating
// stability counter. ready_o asserts once lock has been seen high for
// LOCK_WAIT consecutive synchronised cycles.
module lock_filter
    import sd_clk_pkg::*;
#(
    parameter int LOCK_WAIT = LOCK_WAIT_DEF
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic pll_lock_i,
    output logic ready_o
);

    localparam int             LW       = cnt_width(LOCK_WAIT);
    localparam logic [LW-1:0]  LCNT_MAX = LW'(LOCK_WAIT);

    logic [1:0]    sync_reg;
    logic          lock_s;
    logic [LW-1:0] lcnt_reg;
    logic [LW-1:0] lcnt_next;

    // Synchroniser chain; stage 0 samples the asynchronous lock flag.
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
        if (gi == 0) begin : g_first
            // First stage captures the raw PLL lock.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) sync_reg[gi] <= 1'b0;
                else         sync_reg[gi] <= pll_lock_i;
            end
        end else begin : g_rest
            // Later stages shift the sample along the chain.
            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) sync_reg[gi] <= 1'b0;
                else         sync_reg[gi] <= sync_reg[gi-1];
            end
        end
    end

    assign lock_s = sync_reg[1];

    // Count consecutive lock-high cycles, saturating; any low clears it.
    always_comb begin
        lcnt_next = lcnt_reg;
        if (!lock_s)
            lcnt_next = '0;
        else if (lcnt_reg != LCNT_MAX)
            lcnt_next = lcnt_reg + LW'(1);
    end

    // Stability counter register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) lcnt_reg <= '0;
        else         lcnt_reg <= lcnt_next;
    end

    // Decoded from the register, so it drops on the edge that clears lcnt.
    assign ready_o = (lcnt_reg == LCNT_MAX);

endmodule

// File: rtl/sd_clk_gen.sv
// SD card clock generator: divides the PLL clock to a slow or fast
// SD clock, changing rate or stopping only at the end of a full low
// half-period so no phase is ever shortened.
module sd_clk_gen
    import sd_clk_pkg::*;
#(
    parameter int DIV_SLOW  = DIV_SLOW_DEF,
    parameter int DIV_FAST  = DIV_FAST_DEF,
    parameter int LOCK_WAIT = LOCK_WAIT_DEF
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic pll_lock_i,
    input  logic en_i,
    input  logic fast_i,
    output logic sd_clk_o,
    output logic rise_stb_o,
    output logic fall_stb_o,
    output logic mode_o,
    output logic ready_o
);

    localparam int            CW      = cnt_width(DIV_SLOW);
    localparam logic [CW-1:0] SLOW_M1 = CW'(DIV_SLOW - 1);
    localparam logic [CW-1:0] FAST_M1 = CW'(DIV_FAST - 1);

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          sd_clk_reg, sd_clk_next;
    logic          mode_reg, mode_next;
    logic          rise_stb, fall_stb;
    logic [CW-1:0] half_m1;
    logic          at_end;

    lock_filter #(
        .LOCK_WAIT (LOCK_WAIT)
    ) u_lock_filter (
        .clk_i      (clk_i),
        .rstn_i     (rstn_i),
        .pll_lock_i (pll_lock_i),
        .ready_o    (ready_o)
    );

    assign half_m1 = mode_reg ? FAST_M1 : SLOW_M1;
    assign at_end  = (cnt_reg == half_m1);

    // Next-state, divider and strobe logic.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        sd_clk_next = sd_clk_reg;
        mode_next   = mode_reg;
        rise_stb    = 1'b0;
        fall_stb    = 1'b0;
        case (state_reg)
            WAIT_LOCK: begin
                sd_clk_next = 1'b0;
                cnt_next    = '0;
                if (ready_o) state_next = IDLE;
            end
            IDLE: begin
                sd_clk_next = 1'b0;
                cnt_next    = '0;
                if (!ready_o) begin
                    state_next = WAIT_LOCK;
                end else if (en_i) begin
                    mode_next  = fast_i;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!ready_o) begin
                    // PLL clock is untrustworthy: drop everything, no strobes.
                    state_next  = WAIT_LOCK;
                    sd_clk_next = 1'b0;
                    cnt_next    = '0;
                end else if (at_end) begin
                    cnt_next = '0;
                    if (sd_clk_reg) begin
                        sd_clk_next = 1'b0;
                        fall_stb    = 1'b1;
                    end else if (en_i) begin
                        // Switch point: new rate takes effect on this high phase.
                        sd_clk_next = 1'b1;
                        rise_stb    = 1'b1;
                        mode_next   = fast_i;
                    end else begin
                        // Stop cleanly after a full low phase.
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: begin
                state_next  = WAIT_LOCK;
                sd_clk_next = 1'b0;
                cnt_next    = '0;
            end
        endcase
    end

    // State, counter, SD clock and applied-rate registers.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg  <= WAIT_LOCK;
            cnt_reg    <= '0;
            sd_clk_reg <= 1'b0;
            mode_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            sd_clk_reg <= sd_clk_next;
            mode_reg   <= mode_next;
        end
    end

    assign sd_clk_o   = sd_clk_reg;
    assign rise_stb_o = rise_stb;
    assign fall_stb_o = fall_stb;
    assign mode_o     = mode_reg;

endmodule
